// File: rtl/bisect_sched.sv
`default_nettype none
// ============================================================================
// Module      : bisect_sched (with bisect_sched_pkg)
// Description : Recursive subdivision scheduler. Drives an external
//               combinational bisector and halves an input triangle across
//               its longest XY edge until every piece is small enough,
//               streaming leaves out depth-first on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================

package bisect_sched_pkg;
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } Vertex3D;

    typedef struct packed {
        Vertex3D p;
        Vertex3D q;
        Vertex3D r;
    } Triangle3D;
endpackage

module bisect_sched
    import bisect_sched_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int DEPTH_W     = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  Triangle3D          in_tri,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [33:0]        min_edge_sq,
    input  logic [DEPTH_W-1:0] max_depth,
    output Triangle3D          bis_tri,
    output logic               bis_select,
    input  Triangle3D          bis_out,
    output Triangle3D          out_tri,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               overflow
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        SPLIT_HI = 3'd2,
        SPLIT_LO = 3'd3,
        EMIT     = 3'd4
    } state_t;

    state_t             state;
    Triangle3D          cur;
    logic [DEPTH_W-1:0] cur_lvl;
    logic [33:0]        thr;
    logic [DEPTH_W-1:0] maxd;
    logic [SP_W-1:0]    sp;

    // Pending siblings; contents need no reset because sp gates every read.
    Triangle3D          stk_tri [STACK_DEPTH];
    logic [DEPTH_W-1:0] stk_lvl [STACK_DEPTH];

    logic [33:0]        esq;
    logic               stack_full;
    logic               stack_empty;
    logic               is_leaf;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   top_idx;

    // Squared XY length of one edge: 17-bit signed differences, 34-bit sum.
    function automatic logic [33:0] edge_sq(
        input logic signed [15:0] ax,
        input logic signed [15:0] ay,
        input logic signed [15:0] bx,
        input logic signed [15:0] by
    );
        logic signed [16:0] dx;
        logic signed [16:0] dy;
        logic signed [33:0] sx;
        logic signed [33:0] sy;
        dx = {ax[15], ax} - {bx[15], bx};
        dy = {ay[15], ay} - {by[15], by};
        sx = dx * dx;
        sy = dy * dy;
        return $unsigned(sx) + $unsigned(sy);
    endfunction

    // Longest squared XY edge of the current triangle.
    always_comb begin
        logic [33:0] e_pq;
        logic [33:0] e_qr;
        logic [33:0] e_rp;
        e_pq = edge_sq(cur.p.x, cur.p.y, cur.q.x, cur.q.y);
        e_qr = edge_sq(cur.q.x, cur.q.y, cur.r.x, cur.r.y);
        e_rp = edge_sq(cur.r.x, cur.r.y, cur.p.x, cur.p.y);
        esq  = e_pq;
        if (e_qr > esq) esq = e_qr;
        if (e_rp > esq) esq = e_rp;
    end

    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign is_leaf     = (esq <= thr) || (cur_lvl == maxd) || stack_full;
    assign push_idx    = IDX_W'(sp);
    assign top_idx     = IDX_W'(sp - 1'b1);

    // The bisector always works on the current triangle.
    assign bis_tri = cur;

    // Push the select=1 child while the bisector is presenting it.
    always_ff @(posedge clk) begin
        if (state == SPLIT_HI) begin
            stk_tri[push_idx] <= bis_out;
            stk_lvl[push_idx] <= cur_lvl + 1'b1;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            cur        <= '0;
            cur_lvl    <= '0;
            thr        <= '0;
            maxd       <= '0;
            sp         <= '0;
            in_ready   <= 1'b1;
            bis_select <= 1'b0;
            out_tri    <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur      <= in_tri;
                        cur_lvl  <= '0;
                        thr      <= min_edge_sq;
                        maxd     <= max_depth;
                        overflow <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (is_leaf) begin
                        // Only a full stack can stop a piece that still wants splitting.
                        if ((esq > thr) && (cur_lvl < maxd)) begin
                            overflow <= 1'b1;
                        end
                        out_tri   <= cur;
                        out_last  <= stack_empty;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        bis_select <= 1'b1;
                        state      <= SPLIT_HI;
                    end
                end
                SPLIT_HI: begin
                    sp         <= sp + 1'b1;
                    bis_select <= 1'b0;
                    state      <= SPLIT_LO;
                end
                SPLIT_LO: begin
                    cur     <= bis_out;
                    cur_lvl <= cur_lvl + 1'b1;
                    state   <= CHECK;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (stack_empty) begin
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            cur     <= stk_tri[top_idx];
                            cur_lvl <= stk_lvl[top_idx];
                            sp      <= sp - 1'b1;
                            state   <= CHECK;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/bisect_sched.md
Name: bisect_sched

Overview:
- Recursive subdivision scheduler that sequences the combinational triangle bisector.
- Accepts one projected Triangle3D and repeatedly halves it across its longest XY edge until every piece is small enough. Each resulting leaf triangle is streamed out in depth-first order over a valid/ready interface.
- Sits between the projection stage and the rasteriser. It owns the bisector instance's tri_in and tri_select inputs.

Parameters:
- STACK_DEPTH, 8, number of pending (deferred) triangles held in the internal LIFO.
- DEPTH_W, 4, width of the per-triangle subdivision level counter.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- in_tri  in  Triangle3D  triangle to subdivide
- in_valid  in  1  in_tri valid
- in_ready  out  1  scheduler can accept in_tri
- min_edge_sq  in  34  leaf threshold on squared longest XY edge; sampled at accept
- max_depth  in  DEPTH_W  maximum subdivision level; sampled at accept
- bis_tri  out  Triangle3D  drives bisector tri_in
- bis_select  out  1  drives bisector tri_select
- bis_out  in  Triangle3D  bisector tri_out
- out_tri  out  Triangle3D  leaf triangle
- out_valid  out  1  out_tri valid
- out_ready  in  1  downstream accepts out_tri
- out_last  out  1  final leaf of the current input triangle
- busy  out  1  high in every state except IDLE
- overflow  out  1  sticky flag; cleared on next accept

Behaviour:
- Reset values: all outputs 0, except in_ready=1 (state IDLE). Stack pointer 0, cur and cur_lvl cleared. Reset mid-operation discards the stack and the in-flight triangle with no further output.
- Registers:
  - cur (Triangle3D) and cur_lvl (DEPTH_W).
  - Stack of {Triangle3D, level} entries, STACK_DEPTH deep.
  - thr and maxd, latched at accept.
- Edge metric:
  - esq = max of dx²+dy² over edges PQ, QR, RP.
  - Differences are taken on 16-bit coordinates with sign-extension to 17 bits; squares and sums are computed at 34 bits unsigned. Z is ignored.
  - esq is computed combinationally from cur.
- bis_tri = cur at all times. bis_select = 1 in SPLIT_HI, 0 otherwise.
- FSM states:
  - IDLE: in_ready=1. On in_valid: cur<=in_tri, cur_lvl<=0, thr<=min_edge_sq, maxd<=max_depth, overflow<=0 -> CHECK.
  - CHECK:
    - Leaf if esq <= thr, or cur_lvl == maxd, or the stack is full.
    - Stack full while esq > thr and cur_lvl < maxd sets overflow (sticky); the triangle is emitted unsplit.
    - Leaf -> EMIT, else -> SPLIT_HI.
  - SPLIT_HI: push {bis_out, cur_lvl+1} (the select=1 child) -> SPLIT_LO.
  - SPLIT_LO: cur<=bis_out (the select=0 child), cur_lvl<=cur_lvl+1 -> CHECK.
  - EMIT:
    - out_valid=1, out_tri=cur, out_last=(stack empty).
    - out_tri and out_last hold stable while out_ready=0.
    - On out_ready: if stack empty -> IDLE. Otherwise pop into cur/cur_lvl -> CHECK.
- Order: the select=0 child is always processed before its select=1 sibling (depth-first, pre-order).
- Latency:
  - Accept to first out_valid = 2 cycles when no split occurs.
  - Each split adds 2 cycles (SPLIT_HI, SPLIT_LO) plus 1 cycle of CHECK.
  - Each pop costs 1 cycle of CHECK before EMIT.
- Pop and push never occur in the same cycle. in_ready=0 whenever busy.
- Boundary conditions:
  - max_depth=0 gives pass-through with one leaf.
  - thr >= esq at accept gives pass-through.
  - Degenerate (zero-area) triangles are treated normally by the same rules.
  - A depth limit of maxd bounds the stack occupancy to maxd entries. Overflow can occur only if maxd > STACK_DEPTH.

Test Plan:
- Reset/idle: assert n_rst=0 mid-SPLIT_LO, release -> in_ready=1, busy=0, out_valid=0, overflow=0. The next triangle is processed from an empty stack.
- Single split: P(0,0,0) Q(4,0,0) R(0,4,0), thr=16, maxd=4 -> exactly two leaves.
  - First leaf: (4,0)(2,2)(0,0), out_last=0.
  - Second leaf: (2,2)(0,4)(0,0), out_last=1.
  - First out_valid 5 cycles after accept.
- Pass-through: same triangle with maxd=0, or with thr=32 -> one leaf equal to in_tri, out_last=1, 2 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles during the first leaf -> out_tri and out_last stable, no state advance. Release -> second leaf follows.
- Overflow: STACK_DEPTH=1, thr=0, maxd=3, right triangle with legs 64 -> overflow=1.
  - All leaves are emitted, with exactly one out_last=1.
  - No stack corruption: leaf areas sum to the input area.
- Depth limit: thr=0, maxd=3 on the same triangle -> 8 leaves, all at level 3, in depth-first order.
